// File: rtl/plab4_net_router_domain_sched.sv
// Two-domain scheduler sharing one router input port's path to the switch arbiters.
// Define PLAB4_NET_DOMAIN_SCHED_TDM_EN for strict time-division slots instead of bounded-burst round-robin.
module plab4_net_router_domain_sched #(
    parameter int p_max_burst   = 4,
    parameter int p_slot_cycles = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] reqs_d1,
    input  logic [2:0] reqs_d2,
    input  logic [2:0] grants,
    output logic [2:0] reqs,
    output logic       domain,
    output logic [2:0] grants_d1,
    output logic [2:0] grants_d2,
    output logic       xfer
);

    // Out-of-range configurations elaborate an empty marker block so they are easy to spot.
    if (p_max_burst < 1 || p_max_burst > 255 || p_slot_cycles < 1) begin : g_bad_cfg
    end

    logic sel;

    // Unselected domain's requests are dropped; with no requesters this is naturally 3'b000.
    assign reqs   = sel ? reqs_d2 : reqs_d1;
    assign domain = sel;
    assign xfer   = |(reqs & grants);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_steer
            assign grants_d1[gi] = grants[gi] & ~sel;
            assign grants_d2[gi] = grants[gi] &  sel;
        end
    endgenerate

`ifdef PLAB4_NET_DOMAIN_SCHED_TDM_EN

    localparam int c_slot_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
    localparam logic [c_slot_nbits-1:0] c_slot_last = c_slot_nbits'(p_slot_cycles - 1);

    logic                    slot_owner_reg;
    logic [c_slot_nbits-1:0] slot_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_owner_reg <= 1'b0;
            slot_cnt_reg   <= '0;
        end else if (slot_cnt_reg == c_slot_last) begin
            slot_owner_reg <= ~slot_owner_reg;
            slot_cnt_reg   <= '0;
        end else begin
            slot_cnt_reg   <= slot_cnt_reg + 1'b1;
        end
    end

    // Request-independent selection closes the timing channel between domains.
    assign sel = slot_owner_reg;

`else

    localparam int c_cnt_nbits = $clog2(p_max_burst + 1);
    localparam logic [c_cnt_nbits-1:0] c_max_burst = c_cnt_nbits'(p_max_burst);

    logic                   owner_reg;
    logic [c_cnt_nbits-1:0] cnt_reg;
    logic                   r1;
    logic                   r2;

    assign r1 = |reqs_d1;
    assign r2 = |reqs_d2;

    always_comb begin
        sel = owner_reg;
        if (r1 && !r2) begin
            sel = 1'b0;
        end else if (r2 && !r1) begin
            sel = 1'b1;
        end else if (r1 && r2 && (cnt_reg >= c_max_burst)) begin
            sel = ~owner_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (xfer) begin
            if (sel == owner_reg) begin
                if (cnt_reg < c_max_burst) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                owner_reg <= sel;
                cnt_reg   <= c_cnt_nbits'(1);
            end
        end else if (!r1 && !r2) begin
            cnt_reg <= '0;
        end
        // A denied request holds owner and cnt so the burst resumes where it stalled.
    end

`endif

endmodule

// File: tb/tb_plab4_net_router_domain_sched.sv
// Randomized plus directed bench for plab4_net_router_domain_sched against a behavioural model.
// Honours PLAB4_NET_DOMAIN_SCHED_TDM_EN so the same bench checks either build.
module tb_plab4_net_router_domain_sched;

    localparam int MAXB = 4;
    localparam int SLOT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] reqs_d1, reqs_d2, grants;
    logic [2:0] reqs, grants_d1, grants_d2;
    logic       domain, xfer;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: plain integers describing who owns the port and for how long.
    int m_owner = 0;
    int m_burst = 0;
    int m_slot_pos = 0;
    int m_slot_dom = 0;

    plab4_net_router_domain_sched #(
        .p_max_burst   (MAXB),
        .p_slot_cycles (SLOT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqs_d1   (reqs_d1),
        .reqs_d2   (reqs_d2),
        .grants    (grants),
        .reqs      (reqs),
        .domain    (domain),
        .grants_d1 (grants_d1),
        .grants_d2 (grants_d2),
        .xfer      (xfer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int model_sel(input logic [2:0] d1, input logic [2:0] d2);
`ifdef PLAB4_NET_DOMAIN_SCHED_TDM_EN
        return m_slot_dom;
`else
        if (d1 != 0 && d2 == 0) return 0;
        if (d2 != 0 && d1 == 0) return 1;
        if (d1 != 0 && d2 != 0 && m_burst >= MAXB) return 1 - m_owner;
        return m_owner;
`endif
    endfunction

    // One cycle: apply inputs, check combinational outputs, advance model at the edge.
    task automatic step(input logic rst, input logic [2:0] d1, input logic [2:0] d2,
                        input logic [2:0] g, output int sel_o);
        int       s;
        logic [2:0] er;
        logic     ex;
        reset = rst; reqs_d1 = d1; reqs_d2 = d2; grants = g;
        #1;
        s  = model_sel(d1, d2);
        er = (s == 1) ? d2 : d1;
        ex = ((er & g) != 0);
        check("reqs", 32'(reqs), 32'(er));
        check("domain", 32'(domain), 32'(s));
        check("grants_d1", 32'(grants_d1), (s == 0) ? 32'(g) : 32'd0);
        check("grants_d2", 32'(grants_d2), (s == 1) ? 32'(g) : 32'd0);
        check("xfer", 32'(xfer), 32'(ex));
        $display("cyc rst=%0b d1=%03b d2=%03b g=%03b -> reqs=%03b dom=%0b g1=%03b g2=%03b xfer=%0b",
                 rst, d1, d2, g, reqs, domain, grants_d1, grants_d2, xfer);
        sel_o = s;
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_burst = 0; m_slot_pos = 0; m_slot_dom = 0;
        end else begin
            m_slot_pos++;
            if (m_slot_pos == SLOT) begin
                m_slot_pos = 0;
                m_slot_dom = 1 - m_slot_dom;
            end
            if (ex) begin
                if (s == m_owner) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
                else begin
                    m_owner = s;
                    m_burst = 1;
                end
            end else if (d1 == 0 && d2 == 0) begin
                m_burst = 0;
            end
        end
        #1;
    endtask

    initial begin
        int s;
        int seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        reset = 1'b1; reqs_d1 = '0; reqs_d2 = '0; grants = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with idle inputs.
        step(1'b1, 3'b000, 3'b000, 3'b000, s);
        step(1'b0, 3'b000, 3'b000, 3'b000, s);

        // Lone D1 transfers.
        repeat (3) step(1'b0, 3'b001, 3'b000, 3'b001, s);
        step(1'b0, 3'b000, 3'b000, 3'b000, s);

        // Contending domains with grants held high.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 3'b010, 3'b010, 3'b010, s);
`ifndef PLAB4_NET_DOMAIN_SCHED_TDM_EN
            check("burst_seq", 32'(s), 32'(seq[i]));
`endif
        end
        step(1'b0, 3'b000, 3'b000, 3'b000, s);

        // D2 denied for 5 cycles, then granted.
        repeat (5) step(1'b0, 3'b000, 3'b100, 3'b000, s);
        step(1'b0, 3'b000, 3'b100, 3'b100, s);
        step(1'b0, 3'b001, 3'b100, 3'b000, s);

        // D1 owns with two transfers, then drops out while D2 requests.
        step(1'b0, 3'b000, 3'b000, 3'b000, s);
        repeat (2) step(1'b0, 3'b001, 3'b000, 3'b001, s);
        step(1'b0, 3'b000, 3'b001, 3'b001, s);
        step(1'b0, 3'b001, 3'b001, 3'b001, s);
        step(1'b0, 3'b001, 3'b001, 3'b001, s);

        // Reset mid-burst while both request with grants high.
        step(1'b1, 3'b011, 3'b011, 3'b111, s);
        step(1'b0, 3'b011, 3'b011, 3'b111, s);
`ifndef PLAB4_NET_DOMAIN_SCHED_TDM_EN
        check("post_reset_d1", 32'(s), 32'd0);
`endif

        // Randomized traffic with sparse resets and frequent idle domains.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] d1, d2, g;
            d1 = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
            d2 = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
            g  = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
            step(($urandom_range(0, 63) == 0), d1, d2, g, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
